alu_seq_controller: RTL and testbench

- Next-generation ALU control unit for the RISC-V core.
- Decodes ALUOp/Funct3/Funct7 into a 4-bit ALU Operation code for the full RV32I ALU op set. This includes shifts and SLTU, which the current single-cycle controller lacks.
- Adds an iterative multiply/divide sequencer for the RV32M ops, with an XLEN-parametrised datapath.
- Sits between the main decoder and the ALU/EX stage. It has a valid/ready input handshake, a registered output, and a busy stall for multi-cycle ops.

---
 rtl/alu_ctrl_pkg.sv | 52 +++++
 rtl/md_iter_unit.sv | 141 ++++++++++++++
 rtl/alu_seq_controller.sv | 170 +++++++++++++++++
 tb/tb_alu_seq_controller.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control unit: operation codes, ALUOp and
// Funct7 encodings, the multiply/divide sequencer state type, and the base
// Funct3-to-operation mapping used by both R-type and I-type decode.
`timescale 1ns/1ps
package alu_ctrl_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1100;
  localparam logic [3:0] OP_MD   = 4'b1111;

  localparam logic [1:0] ALUOP_LDST   = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_e;

  // Funct3 mapping shared by R-type (Funct7=0) and I-type arithmetic.
  function automatic logic [3:0] base_op(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/md_iter_unit.sv
// Iterative RV32M datapath: shift-add multiply and restoring divide on
// operand magnitudes, one bit per step, with a down-counter that reports
// the final step. The sign correction is applied combinationally on the
// result output so the controller can capture it in its FIX cycle.
// When EARLY_EN is set, divide-by-zero, signed overflow and multiply by
// zero are recognised at start and the registers are preloaded with the
// final magnitudes so no stepping is needed.
`timescale 1ns/1ps
module md_iter_unit #(
  parameter int XLEN     = 32,
  parameter bit EARLY_EN = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            is_div,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic            step,
  output logic            early,
  output logic            cnt_zero,
  output logic [XLEN-1:0] result
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] dsr_q, dsr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_div_q, is_div_d;
  logic [2:0]      f3_q, f3_d;
  logic            neg_q, neg_d;

  logic            a_signed, b_signed, sa, sb;
  logic            a_zero, b_zero, ovf, special, neg_start;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   shifted, diff, sum;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] mul_res, div_val, div_res;

  // Operand classification at start: signedness, magnitudes, special cases.
  always_comb begin
    a_signed  = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    b_signed  = is_div ? ~funct3[0] : ~funct3[1];
    sa        = a_signed & opa[XLEN-1];
    sb        = b_signed & opb[XLEN-1];
    a_mag     = sa ? -opa : opa;
    b_mag     = sb ? -opb : opb;
    a_zero    = (opa == '0);
    b_zero    = (opb == '0);
    ovf       = is_div & ~funct3[0] & (opa == MOST_NEG) & (opb == '1);
    special   = is_div ? (b_zero | ovf) : (a_zero | b_zero);
    // Quotient of a divide-by-zero stays all ones, so it is never negated;
    // a remainder always follows the dividend's sign.
    if (is_div) neg_start = funct3[1] ? sa : ((sa ^ sb) & ~b_zero);
    else        neg_start = sa ^ sb;
  end

  assign early = EARLY_EN && special;

  // Load on start, otherwise advance one multiply or divide bit per step.
  always_comb begin
    acc_d    = acc_q;
    lo_d     = lo_q;
    dsr_d    = dsr_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    shifted  = {acc_q, lo_q[XLEN-1]};
    diff     = shifted - {1'b0, dsr_q};
    sum      = {1'b0, acc_q} + (lo_q[0] ? {1'b0, dsr_q} : '0);
    if (start) begin
      cnt_d    = CW'(XLEN - 1);
      is_div_d = is_div;
      f3_d     = funct3;
      neg_d    = neg_start;
      acc_d    = '0;
      lo_d     = is_div ? a_mag : b_mag;
      dsr_d    = is_div ? b_mag : a_mag;
      if (early) begin
        if (!is_div)     lo_d = '0;
        else if (b_zero) begin
          acc_d = a_mag;
          lo_d  = '1;
        end
      end
    end else if (step) begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      if (is_div_q) begin
        if (!diff[XLEN]) begin
          acc_d = diff[XLEN-1:0];
          lo_d  = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          acc_d = shifted[XLEN-1:0];
          lo_d  = {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        acc_d = sum[XLEN:1];
        lo_d  = {sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      lo_q     <= '0;
      dsr_q    <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      f3_q     <= 3'b000;
      neg_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      dsr_q    <= dsr_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
    end
  end

  assign cnt_zero = (cnt_q == '0);

  // Sign correction and selection of the architectural result.
  always_comb begin
    prod    = {acc_q, lo_q};
    prod_s  = neg_q ? -prod : prod;
    mul_res = (f3_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    div_val = f3_q[1] ? acc_q : lo_q;
    div_res = neg_q ? -div_val : div_val;
    result  = is_div_q ? div_res : mul_res;
  end

endmodule

// File: rtl/alu_seq_controller.sv
// ALU control unit: decodes ALUOp/Funct7/Funct3 into the ALU operation code
// with a registered, one-cycle output, and sequences RV32M ops through
// md_iter_unit while stalling upstream with busy.
// Build option: MD_EARLY_OUT_EN shortcuts divide-by-zero, signed overflow
// and multiply-by-zero past the iteration phase.
//
//   state | meaning
//   IDLE  | ready for a new instruction; non-M ops complete from here
//   MUL   | shift-add iterations, counter XLEN-1 down to 0
//   DIV   | restoring-divide iterations, counter XLEN-1 down to 0
//   FIX   | sign-corrected result captured into the output register
//   DONE  | out_valid pulse for the M op; still busy
`timescale 1ns/1ps
module alu_seq_controller
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic            out_valid,
  output logic [OP_W-1:0] Operation,
  output logic [XLEN-1:0] md_result,
  output logic            out_illegal,
  output logic            busy
);

`ifdef MD_EARLY_OUT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  md_state_e       state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [OP_W-1:0] operation_q, operation_d;
  logic [XLEN-1:0] md_result_q, md_result_d;
  logic            illegal_q, illegal_d;

  logic [3:0]      dec_op;
  logic            dec_illegal;
  logic            accept;
  logic            md_start, md_step, md_early, md_cnt_zero;
  logic [XLEN-1:0] md_res;

  // Instruction field decode into the 4-bit operation code.
  always_comb begin
    dec_op      = OP_ADD;
    dec_illegal = 1'b0;
    case (ALUOp)
      ALUOP_LDST:   dec_op = OP_ADD;
      ALUOP_BRANCH: dec_op = OP_SUB;
      ALUOP_RTYPE: begin
        if (Funct7 == F7_BASE) begin
          dec_op = base_op(Funct3);
        end else if (Funct7 == F7_ALT && Funct3 == 3'b000) begin
          dec_op = OP_SUB;
        end else if (Funct7 == F7_ALT && Funct3 == 3'b101) begin
          dec_op = OP_SRA;
        end else if (Funct7 == F7_MULDIV) begin
          dec_op = OP_MD;
        end else begin
          dec_op      = OP_ADD;
          dec_illegal = 1'b1;
        end
      end
      ALUOP_ITYPE: begin
        // Immediates carry no SUB/MD forms; only the shift-type bit matters.
        if (Funct3 == 3'b101 && Funct7[5]) dec_op = OP_SRA;
        else                               dec_op = base_op(Funct3);
      end
      default: dec_op = OP_ADD;
    endcase
  end

  assign in_ready = (state_q == ST_IDLE) && !reset;
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != ST_IDLE);

  // Sequencer next state and output register updates.
  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    operation_d = operation_q;
    md_result_d = md_result_q;
    illegal_d   = illegal_q;
    md_start    = 1'b0;
    md_step     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (dec_op == OP_MD) begin
            md_start = 1'b1;
            // Shortcut cases have their result preloaded, so only the
            // capture cycle remains.
            if (md_early)       state_d = ST_FIX;
            else if (Funct3[2]) state_d = ST_DIV;
            else                state_d = ST_MUL;
          end else begin
            out_valid_d = 1'b1;
            operation_d = OP_W'(dec_op);
            md_result_d = '0;
            illegal_d   = dec_illegal;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        md_step = 1'b1;
        if (md_cnt_zero) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d     = ST_DONE;
        out_valid_d = 1'b1;
        operation_d = OP_W'(OP_MD);
        md_result_d = md_res;
        illegal_d   = 1'b0;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset wins over a same-cycle accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      operation_q <= '0;
      md_result_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      operation_q <= operation_d;
      md_result_q <= md_result_d;
      illegal_q   <= illegal_d;
    end
  end

  md_iter_unit #(
    .XLEN     (XLEN),
    .EARLY_EN (EARLY_EN)
  ) u_md (
    .clk      (clk),
    .reset    (reset),
    .start    (md_start),
    .is_div   (Funct3[2]),
    .funct3   (Funct3),
    .opa      (opa),
    .opb      (opb),
    .step     (md_step),
    .early    (md_early),
    .cnt_zero (md_cnt_zero),
    .result   (md_res)
  );

  assign out_valid   = out_valid_q;
  assign Operation   = operation_q;
  assign md_result   = md_result_q;
  assign out_illegal = illegal_q;

endmodule

// File: tb/tb_alu_seq_controller.sv
// Directed bench for alu_seq_controller: expected results are queued when
// an instruction is issued and compared when out_valid appears.
`timescale 1ns/1ps
module tb_alu_seq_controller;

  localparam int XLEN = 32;
  localparam int OP_W = 4;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      ALUOp;
  logic [6:0]      Funct7;
  logic [2:0]      Funct3;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic            out_valid;
  logic [OP_W-1:0] Operation;
  logic [XLEN-1:0] md_result;
  logic            out_illegal;
  logic            busy;

  typedef struct {
    logic [3:0]      op;
    logic [XLEN-1:0] res;
    logic            ill;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  alu_seq_controller #(.XLEN(XLEN), .OP_W(OP_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ALUOp       (ALUOp),
    .Funct7      (Funct7),
    .Funct3      (Funct3),
    .opa         (opa),
    .opb         (opb),
    .out_valid   (out_valid),
    .Operation   (Operation),
    .md_result   (md_result),
    .out_illegal (out_illegal),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every out_valid pulse consumes the oldest expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check("operation", 64'(Operation), 64'(mon_e.op));
        check("md_result", 64'(md_result), 64'(mon_e.res));
        check("out_illegal", 64'(out_illegal), 64'(mon_e.ill));
      end
    end
  end

  // Presents one instruction for exactly one accept edge; returns just after it.
  task automatic issue(input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [3:0] eop, input logic [XLEN-1:0] eres, input logic eill,
                       input bit push);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    ALUOp    = aop;
    Funct7   = f7;
    Funct3   = f3;
    opa      = a;
    opb      = b;
    check("in_ready_at_issue", 64'(in_ready), 64'd1);
    if (push) begin
      e.op  = eop;
      e.res = eres;
      e.ill = eill;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts edges from the accept edge (counted as 1) until out_valid is seen.
  task automatic wait_out(output int lat, output int busy_n, output bit seen);
    lat    = 1;
    busy_n = 0;
    seen   = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_n++;
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic alu_op(input string tag, input logic [1:0] aop, input logic [6:0] f7,
                        input logic [2:0] f3, input logic [3:0] eop, input logic eill);
    int lat, bn;
    bit seen;
    issue(aop, f7, f3, 32'h1234, 32'h5678, eop, '0, eill, 1'b1);
    wait_out(lat, bn, seen);
    check({tag, "_seen"}, 64'(seen), 64'd1);
    check({tag, "_lat"}, 64'(lat), 64'd1);
  endtask

  task automatic md_op(input string tag, input logic [2:0] f3, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] eres);
    int lat, bn;
    bit seen;
    issue(2'b10, 7'b0000001, f3, a, b, 4'b1111, eres, 1'b0, 1'b1);
    wait_out(lat, bn, seen);
    check({tag, "_seen"}, 64'(seen), 64'd1);
    check({tag, "_lat"}, 64'(lat), 64'(XLEN + 2));
    check({tag, "_busy_edges"}, 64'(bn), 64'(XLEN + 2));
  endtask

  logic [3:0] base_tbl [8];
  int  lat, bn, ov_seen;
  bit  seen;

  initial begin
    base_tbl[0] = 4'b0010; base_tbl[1] = 4'b0011; base_tbl[2] = 4'b0111; base_tbl[3] = 4'b1000;
    base_tbl[4] = 4'b1100; base_tbl[5] = 4'b0100; base_tbl[6] = 4'b0001; base_tbl[7] = 4'b0000;
    reset = 1'b1; in_valid = 1'b0; ALUOp = 2'b00; Funct7 = '0; Funct3 = '0; opa = '0; opb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_operation", 64'(Operation), 64'd0);
    check("rst_md_result", 64'(md_result), 64'd0);
    check("rst_illegal", 64'(out_illegal), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b0;
    #1 check("post_rst_in_ready", 64'(in_ready), 64'd1);

    alu_op("r_sub", 2'b10, 7'b0100000, 3'b000, 4'b0110, 1'b0);
    alu_op("i_sra", 2'b11, 7'b0100000, 3'b101, 4'b0101, 1'b0);
    alu_op("i_srl", 2'b11, 7'b0000000, 3'b101, 4'b0100, 1'b0);
    alu_op("ldst", 2'b00, 7'b0000001, 3'b111, 4'b0010, 1'b0);
    alu_op("branch", 2'b01, 7'b0000000, 3'b010, 4'b0110, 1'b0);
    alu_op("r_sra", 2'b10, 7'b0100000, 3'b101, 4'b0101, 1'b0);
    alu_op("i_no_md", 2'b11, 7'b0000001, 3'b000, 4'b0010, 1'b0);
    alu_op("i_no_sub", 2'b11, 7'b0100000, 3'b000, 4'b0010, 1'b0);
    alu_op("ill_f7", 2'b10, 7'b0000010, 3'b000, 4'b0010, 1'b1);
    alu_op("ill_alt_f3", 2'b10, 7'b0100000, 3'b001, 4'b0010, 1'b1);

    // Back-to-back base R-type ops, one accept per edge.
    for (int i = 0; i < 8; i++) begin
      issue(2'b10, 7'b0000000, 3'(i), '0, '0, base_tbl[i], '0, 1'b0, 1'b1);
    end
    repeat (3) @(negedge clk);
    check("b2b_drained", 64'(sb_q.size()), 64'd0);

    md_op("mulhu_ones", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    md_op("mul_neg", 3'b000, 32'd3, 32'hFFFF_FFFB, 32'hFFFF_FFF1);
    md_op("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    md_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    md_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    md_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    md_op("divu_zero", 3'b101, 32'd7, 32'd0, 32'hFFFF_FFFF);
    md_op("remu_zero", 3'b111, 32'd7, 32'd0, 32'd7);
    md_op("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    md_op("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    md_op("div_zero_s", 3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
    md_op("rem_zero_s", 3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);

    // New requests while busy must be ignored and must not disturb the op.
    issue(2'b10, 7'b0000001, 3'b101, 32'd100, 32'd7, 4'b1111, 32'd14, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; ALUOp = 2'b00; Funct7 = '0; Funct3 = '0;
      check("busy_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    wait_out(lat, bn, seen);
    check("divu_stall_seen", 64'(seen), 64'd1);
    check("divu_stall_lat", 64'(lat + 5), 64'(XLEN + 2));

    // Reset ten cycles into a divide aborts it silently.
    issue(2'b10, 7'b0000001, 3'b100, 32'd1000, 32'd3, 4'b1111, '0, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    ov_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) ov_seen++;
    end
    check("abort_no_out_valid", 64'(ov_seen), 64'd0);
    alu_op("after_abort_add", 2'b00, 7'b0000000, 3'b000, 4'b0010, 1'b0);

    repeat (2) @(negedge clk);
    check("sb_empty_at_end", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
